// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;
    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// wait_counter: loadable 3-bit down-counter that stops at zero and flags it
module wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic       zero
);

    logic [2:0] count;

    // Load wins over decrement; the count parks at zero
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != 3'd0)
            count <= count - 3'd1;
    end

    assign zero = count == 3'd0;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_rw,
    input  logic              dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic              mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    state_t            state, state_nxt;
    port_t             last_grant;
    logic              busy, free, cnt_zero;
    logic              if_cand, dm_cand, grant_if, grant_dm;
    logic              lat_rw, lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    wait_counter u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (grant_if | grant_dm),
        .load_val (3'(WAIT_CYCLES)),
        .zero     (cnt_zero)
    );

    assign busy = state != ST_IDLE;
    assign free = ~busy | cnt_zero;

    // Grant from IDLE or on an access's final edge; the finishing port is not re-granted on that edge
    always_comb begin
        if_cand   = if_req & (state != ST_BUSY_IF);
        dm_cand   = dm_req & (state != ST_BUSY_DM);
        grant_dm  = free & dm_cand & (~if_cand | (last_grant == PORT_IF));
        grant_if  = free & if_cand & ~grant_dm;
        state_nxt = grant_dm ? ST_BUSY_DM : grant_if ? ST_BUSY_IF : free ? ST_IDLE : state;
    end

    // State, request latches, read data capture and ready pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= PORT_IF;
            lat_rw     <= MEM_READ;
            lat_size   <= SIZE_BYTE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            state    <= state_nxt;
            if_ready <= (state == ST_BUSY_IF) & cnt_zero;
            dm_ready <= (state == ST_BUSY_DM) & cnt_zero;
            if ((state == ST_BUSY_IF) && cnt_zero)
                if_rdata <= mem_rdata;
            if ((state == ST_BUSY_DM) && cnt_zero && (lat_rw == MEM_READ))
                dm_rdata <= mem_rdata;
            if (grant_if) begin
                last_grant <= PORT_IF;
                lat_rw     <= MEM_READ;
                lat_size   <= SIZE_WORD;
                lat_addr   <= if_addr;
            end
            if (grant_dm) begin
                last_grant <= PORT_DM;
                lat_rw     <= dm_rw;
                lat_size   <= dm_size;
                lat_addr   <= dm_addr;
                lat_wdata  <= dm_wdata;
            end
        end
    end

    assign mem_en    = busy;
    assign mem_rw    = busy & lat_rw;
    assign mem_size  = busy & lat_size;
    assign mem_addr  = busy ? lat_addr : '0;
    assign mem_wdata = busy ? lat_wdata : '0;
    assign stall     = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table, directed and model-checked random tests for the arbiter
module tb_mem_port_arbiter;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        reset, if_req, dm_req, dm_rw, dm_size;
    logic [7:0]  if_addr, dm_addr;
    logic [31:0] dm_wdata, mem_rdata;

    logic        if_ready, dm_ready, mem_en, mem_rw, mem_size, stall;
    logic [31:0] if_rdata, dm_rdata, mem_wdata;
    logic [7:0]  mem_addr;

    logic        z_if_ready, z_dm_ready, z_mem_en, z_mem_rw, z_mem_size, z_stall;
    logic [31:0] z_if_rdata, z_dm_rdata, z_mem_wdata;
    logic [7:0]  z_mem_addr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_rw(dm_rw), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(z_if_ready), .if_rdata(z_if_rdata),
        .dm_req(dm_req), .dm_rw(dm_rw), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ready(z_dm_ready), .dm_rdata(z_dm_rdata),
        .mem_en(z_mem_en), .mem_rw(z_mem_rw), .mem_size(z_mem_size), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(mem_rdata), .stall(z_stall)
    );

    typedef struct {
        logic        rst, ifr;
        logic [7:0]  ifa;
        logic        dmr, rw, sz;
        logic [7:0]  dma;
        logic [31:0] dmw, mrd;
        logic        en, mrw, msz;
        logic [7:0]  ma;
        logic [31:0] mwd;
        logic        ifrdy;
        logic [31:0] ifd;
        logic        dmrdy;
        logic [31:0] dmd;
        logic        stl;
    } vec_t;

    vec_t tbl [15];

    // Transaction-level reference: current owner, cycles left, alternation memory
    int          m_own, m_left, m_last;
    logic        m_rw, m_sz;
    logic [7:0]  m_a;
    logic [31:0] m_wd;
    logic        e_ifr, e_dmr;
    logic [31:0] e_ifd, e_dmd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic en, input logic rw, input logic sz,
                           input logic [7:0] ma, input logic [31:0] wd, input logic ifr,
                           input logic [31:0] ifd, input logic dmr, input logic [31:0] dmd,
                           input logic stl);
        chk({tag, " mem_en"}, 32'(mem_en), 32'(en));
        chk({tag, " mem_rw"}, 32'(mem_rw), 32'(rw));
        chk({tag, " mem_size"}, 32'(mem_size), 32'(sz));
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'(ma));
        if (!en || rw)
            chk({tag, " mem_wdata"}, mem_wdata, wd);
        chk({tag, " if_ready"}, 32'(if_ready), 32'(ifr));
        chk({tag, " if_rdata"}, if_rdata, ifd);
        chk({tag, " dm_ready"}, 32'(dm_ready), 32'(dmr));
        chk({tag, " dm_rdata"}, dm_rdata, dmd);
        chk({tag, " stall"}, 32'(stall), 32'(stl));
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; if_req = v.ifr; if_addr = v.ifa;
        dm_req = v.dmr; dm_rw = v.rw; dm_size = v.sz; dm_addr = v.dma;
        dm_wdata = v.dmw; mem_rdata = v.mrd;
    endtask

    task automatic model_edge();
        bit ci, cd;
        int pick;
        if (reset) begin
            m_own = 0; m_left = 0; m_last = 1;
            m_rw = 1'b0; m_sz = 1'b0; m_a = '0; m_wd = '0;
            e_ifr = 1'b0; e_dmr = 1'b0; e_ifd = '0; e_dmd = '0;
            return;
        end
        e_ifr = 1'b0;
        e_dmr = 1'b0;
        if (m_own != 0 && m_left > 1) begin
            m_left--;
            return;
        end
        if (m_own == 1) begin e_ifr = 1'b1; e_ifd = mem_rdata; end
        if (m_own == 2) begin e_dmr = 1'b1; if (!m_rw) e_dmd = mem_rdata; end
        ci = if_req && m_own != 1;
        cd = dm_req && m_own != 2;
        pick = (ci && cd) ? 3 - m_last : cd ? 2 : ci ? 1 : 0;
        m_own = pick;
        m_left = W + 1;
        if (pick == 1) begin m_rw = 1'b0; m_sz = 1'b1; m_a = if_addr; end
        if (pick == 2) begin m_rw = dm_rw; m_sz = dm_size; m_a = dm_addr; m_wd = dm_wdata; end
        if (pick != 0) m_last = pick;
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_rw = 1'b0; dm_size = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;

        tbl[0]  = '{1'b1,1'b1,8'h10,1'b1,1'b1,1'b1,8'h20,32'hdeadbeef,32'h0,
                    1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1};
        tbl[1]  = tbl[0];
        tbl[2]  = '{1'b0,1'b1,8'h10,1'b1,1'b1,1'b1,8'h20,32'hdeadbeef,32'h0,
                    1'b1,1'b1,1'b1,8'h20,32'hdeadbeef,1'b0,32'h0,1'b0,32'h0,1'b1};
        tbl[3]  = tbl[2];
        tbl[4]  = '{1'b0,1'b1,8'h10,1'b1,1'b1,1'b1,8'h20,32'hdeadbeef,32'h0,
                    1'b1,1'b0,1'b1,8'h10,32'h0,1'b0,32'h0,1'b1,32'h0,1'b1};
        tbl[5]  = '{1'b0,1'b1,8'h10,1'b1,1'b0,1'b0,8'h23,32'h0,32'he3a01005,
                    1'b1,1'b0,1'b1,8'h10,32'h0,1'b0,32'h0,1'b0,32'h0,1'b1};
        tbl[6]  = '{1'b0,1'b1,8'h10,1'b1,1'b0,1'b0,8'h23,32'h0,32'he3a01005,
                    1'b1,1'b0,1'b0,8'h23,32'h0,1'b1,32'he3a01005,1'b0,32'h0,1'b1};
        tbl[7]  = '{1'b0,1'b0,8'h10,1'b1,1'b0,1'b0,8'h23,32'h0,32'h000000ab,
                    1'b1,1'b0,1'b0,8'h23,32'h0,1'b0,32'he3a01005,1'b0,32'h0,1'b1};
        tbl[8]  = '{1'b0,1'b0,8'h10,1'b1,1'b0,1'b0,8'h23,32'h0,32'h000000ab,
                    1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,32'he3a01005,1'b1,32'h000000ab,1'b0};
        tbl[9]  = '{1'b0,1'b0,8'h10,1'b0,1'b0,1'b0,8'h23,32'h0,32'h0,
                    1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,32'he3a01005,1'b0,32'h000000ab,1'b0};
        tbl[10] = '{1'b0,1'b1,8'h14,1'b1,1'b0,1'b1,8'h30,32'h0,32'h0,
                    1'b1,1'b0,1'b1,8'h14,32'h0,1'b0,32'he3a01005,1'b0,32'h000000ab,1'b1};
        tbl[11] = tbl[10];
        tbl[12] = '{1'b0,1'b1,8'h14,1'b1,1'b0,1'b1,8'h30,32'h0,32'h11223344,
                    1'b1,1'b0,1'b1,8'h30,32'h0,1'b1,32'h11223344,1'b0,32'h000000ab,1'b1};
        tbl[13] = '{1'b0,1'b0,8'h14,1'b0,1'b0,1'b1,8'h30,32'h0,32'h0,
                    1'b1,1'b0,1'b1,8'h30,32'h0,1'b0,32'h11223344,1'b0,32'h000000ab,1'b0};
        tbl[14] = '{1'b0,1'b0,8'h14,1'b0,1'b0,1'b1,8'h30,32'h0,32'h55667788,
                    1'b0,1'b0,1'b0,8'h00,32'h0,1'b0,32'h11223344,1'b1,32'h55667788,1'b0};

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            @(posedge clk);
            #1;
            chk_all($sformatf("row%0d", i), tbl[i].en, tbl[i].mrw, tbl[i].msz, tbl[i].ma,
                    tbl[i].mwd, tbl[i].ifrdy, tbl[i].ifd, tbl[i].dmrdy, tbl[i].dmd, tbl[i].stl);
        end

        // Reset in the first busy cycle of a store kills it without a ready pulse
        @(negedge clk);
        reset = 1'b1; if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        reset = 1'b0; dm_req = 1'b1; dm_rw = 1'b1; dm_size = 1'b1;
        dm_addr = 8'h40; dm_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        chk("rst_mid granted mem_en", 32'(mem_en), 32'd1);
        chk("rst_mid granted mem_wdata", mem_wdata, 32'h12345678);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid mem_en", 32'(mem_en), 32'd0);
        chk("rst_mid dm_ready", 32'(dm_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0; dm_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_mid after%0d dm_ready", k), 32'(dm_ready), 32'd0);
            chk($sformatf("rst_mid after%0d mem_en", k), 32'(mem_en), 32'd0);
        end

        // Zero-wait instance with both requesters always asking: strict DM/IF alternation
        @(negedge clk);
        reset = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_rw = 1'b1; if_addr = 8'h08;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("w0 cyc%0d mem_en", k), 32'(z_mem_en), 32'd1);
            chk($sformatf("w0 cyc%0d mem_rw", k), 32'(z_mem_rw), 32'(k % 2 == 0));
            chk($sformatf("w0 cyc%0d dm_ready", k), 32'(z_dm_ready), 32'(k % 2 == 1));
            chk($sformatf("w0 cyc%0d if_ready", k), 32'(z_if_ready), 32'(k > 0 && k % 2 == 0));
        end

        // Random traffic, including occasional reset, against the reference
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset     = (c == 0) || ($urandom_range(0, 59) == 0);
            if_req    = $urandom_range(0, 3) != 0;
            dm_req    = $urandom_range(0, 2) != 0;
            dm_rw     = 1'($urandom);
            dm_size   = 1'($urandom);
            if_addr   = 8'($urandom);
            dm_addr   = 8'($urandom);
            dm_wdata  = $urandom;
            mem_rdata = $urandom;
            @(posedge clk);
            model_edge();
            #1;
            chk_all($sformatf("rnd%0d", c), m_own != 0, (m_own != 0) & m_rw, (m_own != 0) & m_sz,
                    (m_own != 0) ? m_a : 8'h00, (m_own != 0) ? m_wd : 32'h0, e_ifr, e_ifd,
                    e_dmr, e_dmd, (if_req & ~e_ifr) | (dm_req & ~e_dmr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
